// File: rtl/fpga_serializer_rr.sv
// N-input round-robin serializer: slices each granted word into tagged chunks on one PC channel.
// Optional FPGA_SER_TAIL_FLAG_EN marks the final chunk of every word in out_code's MSB.
module fpga_serializer_rr #(
    parameter int                      N_IN    = 4,
    parameter int                      NINW    = 48,
    parameter int                      NPCcode = 8,
    parameter int                      NPCdata = 24,
    parameter logic [4*N_IN-1:0]       NCHUNKS = {4'd1, 4'd1, 4'd2, 4'd2},
    parameter logic [NPCcode*N_IN-1:0] CODES   = {8'd16, 8'd15, 8'd14, 8'd13}
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_IN*NINW-1:0]   in_d,
    input  logic [N_IN-1:0]        in_v,
    output logic [N_IN-1:0]        in_a,
    output logic [NPCcode-1:0]     out_code,
    output logic [NPCdata-1:0]     out_payload,
    output logic                   out_v,
    input  logic                   out_a
);

    function automatic int max_chunks();
        int m;
        m = 1;
        for (int i = 0; i < N_IN; i++) begin
            if (int'(NCHUNKS[4*i +: 4]) > m) m = int'(NCHUNKS[4*i +: 4]);
        end
        return m;
    endfunction

    localparam int SHW_C = max_chunks() * NPCdata;
    localparam int SHW   = (SHW_C > NINW) ? SHW_C : NINW;
    localparam int PW    = (N_IN > 1) ? $clog2(N_IN) : 1;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_chk
            if (NCHUNKS[4*gi +: 4] == 4'd0) begin : g_zero
                $error("fpga_serializer_rr: NCHUNKS entry %0d is zero", gi);
            end
            if (int'(NCHUNKS[4*gi +: 4]) * NPCdata < NINW) begin : g_width
                $error("fpga_serializer_rr: NCHUNKS entry %0d too small for NINW", gi);
            end
`ifdef FPGA_SER_TAIL_FLAG_EN
            if (CODES[NPCcode*gi + NPCcode-1]) begin : g_code
                $error("fpga_serializer_rr: CODES entry %0d uses the tail-flag bit", gi);
            end
`endif
        end
    endgenerate

    function automatic logic [NPCcode-1:0] code_of(input logic [PW-1:0] g);
        return CODES[NPCcode*int'(g) +: NPCcode];
    endfunction

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_q, state_d;
    logic [SHW-1:0]      shreg_q, shreg_d;
    logic [PW-1:0]       gsel_q, gsel_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [3:0]          chunks_left_q, chunks_left_d;
    logic                out_v_q, out_v_d;
    logic [NPCcode-1:0]  out_code_q, out_code_d;

    logic                grant_any;
    logic [PW-1:0]       grant_idx;
    logic                last_accept;
    logic                take;
    logic [3:0]          ld_chunks;

    // First valid stream strictly after rr_ptr, wrapping around.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= N_IN; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % N_IN;
            if (!grant_any && in_v[idx]) begin
                grant_any = 1'b1;
                grant_idx = PW'(idx);
            end
        end
    end

    always_comb begin
        last_accept   = (state_q == SEND) && out_a && (chunks_left_q == 4'd1);
        take          = reset && grant_any && ((state_q == IDLE) || last_accept);
        ld_chunks     = NCHUNKS[4*int'(grant_idx) +: 4];
        for (int i = 0; i < N_IN; i++) begin
            in_a[i] = take && (grant_idx == PW'(i));
        end

        state_d       = state_q;
        shreg_d       = shreg_q;
        gsel_d        = gsel_q;
        rr_ptr_d      = rr_ptr_q;
        chunks_left_d = chunks_left_q;
        out_v_d       = out_v_q;
        out_code_d    = out_code_q;

        if (take) begin
            state_d       = SEND;
            shreg_d       = SHW'(in_d[NINW*int'(grant_idx) +: NINW]);
            gsel_d        = grant_idx;
            rr_ptr_d      = grant_idx;
            chunks_left_d = ld_chunks;
            out_v_d       = 1'b1;
            out_code_d    = code_of(grant_idx);
`ifdef FPGA_SER_TAIL_FLAG_EN
            out_code_d[NPCcode-1] = (ld_chunks == 4'd1);
`endif
        end else if ((state_q == SEND) && out_a) begin
            shreg_d       = shreg_q >> NPCdata;
            chunks_left_d = chunks_left_q - 4'd1;
            out_code_d    = code_of(gsel_q);
`ifdef FPGA_SER_TAIL_FLAG_EN
            out_code_d[NPCcode-1] = (chunks_left_q == 4'd2);
`endif
            if (chunks_left_q == 4'd1) begin
                state_d = IDLE;
                out_v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            gsel_q        <= '0;
            rr_ptr_q      <= PW'(N_IN - 1);
            chunks_left_q <= '0;
            out_v_q       <= 1'b0;
            out_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            gsel_q        <= gsel_d;
            rr_ptr_q      <= rr_ptr_d;
            chunks_left_q <= chunks_left_d;
            out_v_q       <= out_v_d;
            out_code_q    <= out_code_d;
        end
    end

    assign out_v       = out_v_q;
    assign out_code    = out_code_q;
    assign out_payload = shreg_q[NPCdata-1:0];

endmodule

// File: tb/tb_fpga_serializer_rr.sv
// Bench for fpga_serializer_rr: directed scenarios plus random traffic against a queue-based model.
module tb_fpga_serializer_rr;
    localparam int N_IN = 4, NINW = 48, NPCcode = 8, NPCdata = 24;
    localparam logic [4*N_IN-1:0]       NCH = {4'd1, 4'd1, 4'd2, 4'd2};
    localparam logic [NPCcode*N_IN-1:0] CDS = {8'd16, 8'd15, 8'd14, 8'd13};

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N_IN*NINW-1:0]  in_d;
    logic [N_IN-1:0]       in_v, in_a;
    logic [NPCcode-1:0]    out_code;
    logic [NPCdata-1:0]    out_payload;
    logic                  out_v, out_a;

    fpga_serializer_rr #(
        .N_IN(N_IN), .NINW(NINW), .NPCcode(NPCcode), .NPCdata(NPCdata),
        .NCHUNKS(NCH), .CODES(CDS)
    ) dut (
        .clk(clk), .reset(reset), .in_d(in_d), .in_v(in_v), .in_a(in_a),
        .out_code(out_code), .out_payload(out_payload), .out_v(out_v), .out_a(out_a)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NPCcode-1:0] code;
        logic [NPCdata-1:0] payload;
    } chunk_t;

    logic [NINW-1:0]      pend [N_IN][$];
    chunk_t               expq[$];
    chunk_t               obs[$];
    int                   grants[$];
    int                   last_g;
    logic                 out_a_drv;
    logic [N_IN-1:0]      hide;
    logic [4*N_IN-1:0]    nch_v = NCH;
    logic [NPCcode*N_IN-1:0] cds_v = CDS;
    int                   total = 0;
    int                   bad = 0;

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Spec-level model: a granted word becomes NCHUNKS LSB-first tagged chunks.
    task automatic push_word(input int g, input logic [NINW-1:0] w);
        int n;
        logic [NINW-1:0] sh;
        chunk_t ch;
        n = int'(nch_v[4*g +: 4]);
        for (int k = 0; k < n; k++) begin
            sh = w >> (NPCdata * k);
            ch.payload = sh[NPCdata-1:0];
            ch.code = cds_v[NPCcode*g +: NPCcode];
`ifdef FPGA_SER_TAIL_FLAG_EN
            ch.code[NPCcode-1] = (k == n - 1);
`endif
            expq.push_back(ch);
        end
    endtask

    task automatic cycle();
        int g;
        logic allowed;
        logic [N_IN-1:0] exp_a;
        chunk_t dch;
        for (int i = 0; i < N_IN; i++) begin
            in_v[i] = (pend[i].size() > 0) && !hide[i];
            in_d[NINW*i +: NINW] = (pend[i].size() > 0) ? pend[i][0] : '0;
        end
        out_a = out_a_drv;
        #3;
        check("out_v", 64'(out_v), 64'(expq.size() > 0));
        if (expq.size() > 0) begin
            check("out_code", 64'(out_code), 64'(expq[0].code));
            check("out_payload", 64'(out_payload), 64'(expq[0].payload));
        end
        allowed = (expq.size() == 0) || (out_a && expq.size() == 1);
        g = -1;
        exp_a = '0;
        if (allowed) begin
            for (int k = 1; k <= N_IN; k++) begin
                if (g < 0 && in_v[(last_g + k) % N_IN]) g = (last_g + k) % N_IN;
            end
        end
        if (g >= 0) exp_a[g] = 1'b1;
        check("in_a", 64'(in_a), 64'(exp_a));
        if (out_v && out_a) begin
            dch.code = out_code;
            dch.payload = out_payload;
            obs.push_back(dch);
        end
        if (out_a && expq.size() > 0) void'(expq.pop_front());
        if (g >= 0) begin
            push_word(g, pend[g].pop_front());
            grants.push_back(g);
            last_g = g;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input int maxc);
        int c;
        int busy;
        c = 0;
        busy = 1;
        while (busy != 0 && c < maxc) begin
            busy = expq.size();
            for (int i = 0; i < N_IN; i++) busy += pend[i].size();
            if (busy != 0) cycle();
            c++;
        end
        check("drain_timeout", 64'(busy), 64'd0);
    endtask

    task automatic reset_now();
        reset = 1'b0;
        #1;
        check("rst_out_v", 64'(out_v), 64'd0);
        check("rst_in_a", 64'(in_a), 64'd0);
        check("rst_code", 64'(out_code), 64'd0);
        check("rst_payload", 64'(out_payload), 64'd0);
        expq.delete();
        last_g = N_IN - 1;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [NINW-1:0] w;
        logic [NPCcode-1:0] c0, c1, c2;
        reset = 1'b1; in_v = '0; in_d = '0; out_a = 1'b0;
        out_a_drv = 1'b1; hide = '0; last_g = N_IN - 1;
        @(posedge clk);
        #1;
        in_v = 4'b0001;
        reset_now();
        in_v = '0;

        // Single word on input 0.
        obs.delete();
        pend[0].push_back(48'hABCDEF_123456);
        run_until_idle(20);
        cycle();
`ifdef FPGA_SER_TAIL_FLAG_EN
        c0 = 8'h0D; c1 = 8'h8D; c2 = 8'h8F;
`else
        c0 = 8'd13; c1 = 8'd13; c2 = 8'd15;
`endif
        check("t1_count", 64'(obs.size()), 64'd2);
        check("t1_c0", 64'(obs[0]), 64'({c0, 24'h123456}));
        check("t1_c1", 64'(obs[1]), 64'({c1, 24'hABCDEF}));

        // Fairness from reset with every stream busy.
        reset_now();
        grants.delete();
        for (int i = 0; i < N_IN; i++) begin
            pend[i].push_back({$urandom, $urandom});
            pend[i].push_back({$urandom, $urandom});
        end
        run_until_idle(100);
        check("fair_g0", 64'(grants[0]), 64'd0);
        check("fair_g1", 64'(grants[1]), 64'd1);
        check("fair_g2", 64'(grants[2]), 64'd2);
        check("fair_g3", 64'(grants[3]), 64'd3);
        check("fair_g4", 64'(grants[4]), 64'd0);

        // Backpressure on input 1's last chunk while input 0 waits.
        pend[1].push_back({$urandom, $urandom});
        cycle();
        cycle();
        out_a_drv = 1'b0;
        pend[0].push_back({$urandom, $urandom});
        repeat (5) cycle();
        out_a_drv = 1'b1;
        run_until_idle(20);

        // Zero-bubble handoff from input 2 to input 3.
        grants.delete();
        obs.delete();
        pend[2].push_back(48'h0000_00_777777);
        pend[3].push_back(48'h0000_00_888888);
        run_until_idle(20);
        check("zb_order", 64'({grants[0], grants[1]}), {32'd2, 32'd3});
        check("zb_c2", 64'(obs[0]), 64'({c2, 24'h777777}));

        // Reset in the middle of an input-0 word.
        w = {$urandom, $urandom};
        pend[0].push_back(w);
        cycle();
        cycle();
        pend[0].push_front(w);
        for (int i = 0; i < N_IN; i++) in_v[i] = (pend[i].size() > 0);
        reset_now();
        obs.delete();
        grants.delete();
        run_until_idle(20);
        check("rst_regrant", 64'(grants[0]), 64'd0);
        check("rst_chunk0", 64'(obs[0].payload), 64'(w[NPCdata-1:0]));

        // Random traffic with backpressure and valid dropouts.
        for (int c = 0; c < 400; c++) begin
            out_a_drv = ($urandom_range(0, 3) != 0);
            hide = N_IN'($urandom_range(0, 15)) & N_IN'($urandom_range(0, 15)) & N_IN'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                int s;
                s = $urandom_range(0, N_IN - 1);
                if (pend[s].size() < 3) pend[s].push_back({$urandom, $urandom});
            end
            cycle();
        end
        hide = '0;
        out_a_drv = 1'b1;
        run_until_idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fpga_serializer_rr.md
# fpga_serializer_rr

Parametrised N-input upstream serializer and merger for the FPGA-to-PC path. Each input stream carries one word of up to NINW bits. The block slices each accepted word into NPCdata-bit payload chunks, tags every chunk with that input's fixed code, and emits the chunks on one PC word channel. Arbitration is round-robin with word atomicity: all chunks of one word leave consecutively. It replaces the fixed two-input heartbeat/spike-filter serializer, so any number of upstream sources can share the PC link.

## Interface
- N_IN, 4, number of input streams (1..16)
- NINW, 48, input word width per stream (all inputs share the packed width)
- NPCcode, 8, code field width
- NPCdata, 24, payload width
- NCHUNKS, {4'd1,4'd1,4'd2,4'd2}, packed 4-bit per-input chunk count; entry i is at bits [4i+3:4i], legal values 1..15
- CODES, {8'd16,8'd15,8'd14,8'd13}, packed NPCcode-bit per-input code; entry i is at bits [NPCcode*i +: NPCcode]
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset
- in_d  input  N_IN*NINW  input words; stream i occupies [NINW*i +: NINW]
- in_v  input  N_IN  per-stream valid
- in_a  output  N_IN  per-stream ack; one-hot or zero
- out_code  output  NPCcode  code of the current chunk
- out_payload  output  NPCdata  payload of the current chunk
- out_v  output  1  chunk valid
- out_a  input  1  downstream ack

## Operation
- A transfer occurs on any rising edge where valid and ack are both high. This applies on every channel.
- Elaboration checks, which must fail compile on violation:
  - NCHUNKS[i]*NPCdata >= NINW for every i.
  - NCHUNKS[i] is nonzero for every i.
  - With FPGA_SER_TAIL_FLAG_EN defined, the MSB of every CODES entry is 0.
- Word i is zero-extended to NCHUNKS[i]*NPCdata bits. Chunks are emitted least-significant first. Chunk k carries bits [NPCdata*k +: NPCdata].
- State machine, IDLE and SEND:
  - IDLE: out_v=0. If any in_v is high, grant g is the first valid index scanning upward (with wrap) from rr_ptr+1. in_a[g]=1 combinationally in that cycle. At the edge, the block latches the word into the shift register, records g, sets chunks_left=NCHUNKS[g], sets rr_ptr=g and moves to SEND.
  - SEND: out_v=1, out_payload=shreg[NPCdata-1:0], out_code=CODES[g]. On out_a: shreg shifts right by NPCdata and chunks_left decrements.
    - If the accepted chunk is the last one (chunks_left==1) and some in_v is high: grant, ack and latch a new word in that same cycle using the IDLE rules, and stay in SEND. This path gives zero-bubble back-to-back words.
    - If the accepted chunk is the last one and no in_v is high: move to IDLE.
- in_a is never asserted in SEND except in the last-chunk-accepted cycle. This creates a combinational out_a -> in_a path, which is intended.
- Input words that are not granted remain pending. The block never drops a word except on reset.
- With no backpressure, every input with in_v continuously high is served within N_IN words. No input starves.

## Timing
- Reset (asynchronous, active-low) forces:
  - state=IDLE, out_v=0, in_a=0
  - out_code=0, out_payload=0
  - chunks_left=0, rr_ptr=N_IN-1, so input 0 wins first
- If reset asserts mid-word, the partially sent word is discarded. out_v falls immediately, without waiting for clk.
- Latency: a word accepted at edge n has its first chunk valid after edge n, i.e. in cycle n+1.
- Throughput: one chunk per cycle under a continuous out_a.
- While out_v=1 and out_a=0, out_code and out_payload stay stable.
- If in_v for a granted stream drops without an ack, no capture occurs and the grant is re-evaluated next cycle.

## Configuration
- FPGA_SER_TAIL_FLAG_EN:
  - Defined: out_code[NPCcode-1] = 1 on the final chunk of every word and 0 otherwise. The remaining code bits are CODES[g]. This lets the PC delimit words without a length table.
  - Undefined: out_code = CODES[g] on every chunk, with no tail marking.

## Test plan
- Single word, no backpressure: input 0 sends in_d[47:0]=48'hABCDEF_123456. Required output: (code 13, payload 24'h123456), then (code 13, payload 24'hABCDEF) on consecutive cycles, then IDLE.
- Fairness: all four in_v held high, out_a=1. Required grant order is 0,1,2,3,0. Chunks seen per word are 2,2,1,1. No cycle has out_v=0 after the first chunk.
- Backpressure: out_a held low for 5 cycles mid-word on input 1. out_v, out_code=14 and out_payload stay constant. No in_a pulses during the stall. Sending resumes exactly when out_a rises.
- Zero-bubble handoff: input 2 (1 chunk) and input 3 (1 chunk) valid back-to-back. in_a[3] pulses in the same cycle input 2's chunk is accepted. The code-16 chunk follows on the next cycle.
- Reset mid-word: reset asserts low after the first chunk of input 0. out_v drops asynchronously. After release, the resent word starts again from chunk 0 and rr_ptr=N_IN-1.
- With FPGA_SER_TAIL_FLAG_EN defined: the single-word test gives codes 8'h0D then 8'h8D. Input 2 words give 8'h8F only.
